// File: rtl/asrv32_aclint_pkg.sv
// Shared definitions for the ASRV32 core-local interruptor: register offsets,
// decoded register selector and the byte-enable merge helper.
package asrv32_aclint_pkg;

   localparam logic [15:0] MSIP_OFS     = 16'h0000;
   localparam logic [15:0] MTIMECMP_OFS = 16'h4000;
   localparam logic [15:0] MTIME_LO_OFS = 16'hBFF8;
   localparam logic [15:0] MTIME_HI_OFS = 16'hBFFC;

   typedef enum logic [2:0] {
      REG_NONE,
      REG_MSIP,
      REG_CMP_LO,
      REG_CMP_HI,
      REG_MTIME_LO,
      REG_MTIME_HI
   } reg_sel_e;

   // Replace only the bytes whose enable bit is set.
   function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  mask);
      logic [31:0] res;
      res = old_val;
      for (int b = 0; b < 4; b++) begin
         if (mask[b]) res[8*b +: 8] = new_val[8*b +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/asrv32_mtime_counter.sv
// Shared 64-bit machine timer with tick prescaler; a bus write to either half
// takes precedence over that cycle's increment.
module asrv32_mtime_counter
   import asrv32_aclint_pkg::*;
#(
   parameter int TICK_DIV = 1
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_wr_lo,
   input  logic        i_wr_hi,
   input  logic [31:0] i_wdata_lo,
   input  logic [31:0] i_wdata_hi,
   output logic [63:0] o_mtime,
   output logic        o_tick
);

   localparam int               DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

   logic [DIV_W-1:0] div_cnt;

   assign o_tick = (div_cnt == DIV_LAST);

   // NOTE: sequential state uses <= so every flop samples pre-edge values.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= o_tick ? '0 : div_cnt + DIV_W'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_mtime <= '0;
      end else if (i_wr_lo || i_wr_hi) begin
         if (i_wr_lo) o_mtime[31:0]  <= i_wdata_lo;
         if (i_wr_hi) o_mtime[63:32] <= i_wdata_hi;
      end else if (o_tick) begin
         o_mtime <= o_mtime + 64'd1;
      end
   end

endmodule

// File: rtl/asrv32_aclint.sv
// Machine-level CLINT: per-hart MSIP/MTIMECMP, shared MTIME with coherent
// lo/hi read shadow, single-cycle stb/ack bus with error on unmapped access.
module asrv32_aclint
   import asrv32_aclint_pkg::*;
#(
   parameter int N_HARTS  = 1,
   parameter int TICK_DIV = 1
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic [31:0]        i_addr,
   input  logic [31:0]        i_wdata,
   input  logic               i_wr_en,
   input  logic [3:0]         i_wr_mask,
   input  logic               i_stb,
   output logic [31:0]        o_rdata,
   output logic               o_ack,
   output logic               o_err,
   output logic [N_HARTS-1:0] o_timer_interrupt,
   output logic [N_HARTS-1:0] o_software_interrupt
);

   logic [15:0] ofs;
   reg_sel_e    sel;
   logic [2:0]  hart;
   logic [31:0] rd_val;
   logic [63:0] mtime;
   logic [63:0] cmp_arr [N_HARTS];
   logic [31:0] shadow_hi;
   logic        shadow_vld;
   logic        bus_wr, bus_rd;
   logic        mtime_wr_lo, mtime_wr_hi;
   logic        unused_addr_hi;
   logic        unused_tick;

   assign ofs            = i_addr[15:0];
   assign unused_addr_hi = ^i_addr[31:16];
   assign bus_wr         = i_stb && i_wr_en;
   assign bus_rd         = i_stb && !i_wr_en;

   // NOTE: defaults first so no path leaves sel/hart unassigned, which would infer a latch.
   always_comb begin
      sel  = REG_NONE;
      hart = '0;
      if (ofs[1:0] == 2'b00) begin
         if (ofs[15:5] == MSIP_OFS[15:5]) begin
            hart = ofs[4:2];
            if (int'(hart) < N_HARTS) sel = REG_MSIP;
         end else if (ofs[15:6] == MTIMECMP_OFS[15:6]) begin
            hart = ofs[5:3];
            if (int'(hart) < N_HARTS) sel = ofs[2] ? REG_CMP_HI : REG_CMP_LO;
         end else if (ofs == MTIME_LO_OFS) begin
            sel = REG_MTIME_LO;
         end else if (ofs == MTIME_HI_OFS) begin
            sel = REG_MTIME_HI;
         end
      end
   end

   assign mtime_wr_lo = bus_wr && (sel == REG_MTIME_LO);
   assign mtime_wr_hi = bus_wr && (sel == REG_MTIME_HI);

   asrv32_mtime_counter #(
      .TICK_DIV (TICK_DIV)
   ) u_mtime (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_wr_lo    (mtime_wr_lo),
      .i_wr_hi    (mtime_wr_hi),
      .i_wdata_lo (merge_bytes(mtime[31:0], i_wdata, i_wr_mask)),
      .i_wdata_hi (merge_bytes(mtime[63:32], i_wdata, i_wr_mask)),
      .o_mtime    (mtime),
      .o_tick     (unused_tick)
   );

   for (genvar h = 0; h < N_HARTS; h++) begin : g_hart
      logic        hit;
      logic [63:0] cmp_q;
      logic        msip_q;
      logic        tirq_q;

      assign hit = bus_wr && (hart == 3'(h));

      // NOTE: the compare registers are few and must come up all-ones so no
      // timer interrupt fires out of reset, hence they sit on the async reset.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n) begin
            cmp_q  <= '1;
            msip_q <= 1'b0;
            tirq_q <= 1'b0;
         end else begin
            if (hit && sel == REG_MSIP && i_wr_mask[0]) msip_q <= i_wdata[0];
            if (hit && sel == REG_CMP_LO) cmp_q[31:0]  <= merge_bytes(cmp_q[31:0], i_wdata, i_wr_mask);
            if (hit && sel == REG_CMP_HI) cmp_q[63:32] <= merge_bytes(cmp_q[63:32], i_wdata, i_wr_mask);
            tirq_q <= (mtime >= cmp_q);
         end
      end

      assign cmp_arr[h]              = cmp_q;
      assign o_software_interrupt[h] = msip_q;
      assign o_timer_interrupt[h]    = tirq_q;
   end

   always_comb begin
      rd_val = '0;
      for (int h = 0; h < N_HARTS; h++) begin
         if (hart == 3'(h)) begin
            case (sel)
               REG_MSIP:   rd_val = {31'b0, o_software_interrupt[h]};
               REG_CMP_LO: rd_val = cmp_arr[h][31:0];
               REG_CMP_HI: rd_val = cmp_arr[h][63:32];
               default:    ;
            endcase
         end
      end
      if (sel == REG_MTIME_LO)      rd_val = mtime[31:0];
      else if (sel == REG_MTIME_HI) rd_val = shadow_vld ? shadow_hi : mtime[63:32];
   end

   // Lo read latches the high word so a following hi read is carry-coherent.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         shadow_hi  <= '0;
         shadow_vld <= 1'b0;
      end else if (mtime_wr_lo || mtime_wr_hi) begin
         shadow_vld <= 1'b0;
      end else if (bus_rd && sel == REG_MTIME_LO) begin
         shadow_hi  <= mtime[63:32];
         shadow_vld <= 1'b1;
      end else if (bus_rd && sel == REG_MTIME_HI) begin
         shadow_vld <= 1'b0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_ack   <= 1'b0;
         o_err   <= 1'b0;
         o_rdata <= '0;
      end else begin
         o_ack   <= i_stb;
         o_err   <= i_stb && (sel == REG_NONE);
         o_rdata <= bus_rd ? rd_val : '0;
      end
   end

endmodule

// File: doc/asrv32_aclint.md
# asrv32_aclint

Parametrised machine-level core-local interruptor for the ASRV32 SoC. It provides a shared 64-bit MTIME counter with a programmable tick prescaler, plus one MTIMECMP register and one MSIP register per hart. It also adds byte-masked writes, coherent 64-bit MTIME reads and an error response for unmapped accesses. It sits behind the peripheral bus controller as a memory-mapped device and uses the same stb/ack data handshake as main memory.

## Interface
- `N_HARTS`, 1: number of harts; legal range 1..8.
- `TICK_DIV`, 1: MTIME increments once every `TICK_DIV` clocks; must be ≥1.
- `i_clk` in 1: system clock.
- `i_rst_n` in 1: reset, asynchronous, active-low.
- `i_addr` in 32: byte address. Only `i_addr[15:0]` (offset) is decoded; device select is done by the bus controller.
- `i_wdata` in 32: write data.
- `i_wr_en` in 1: 1 = write, 0 = read; qualified by `i_stb`.
- `i_wr_mask` in 4: byte enables for writes.
- `i_stb` in 1: access request, one access per cycle.
- `o_rdata` out 32: read data; valid while `o_ack`=1.
- `o_ack` out 1: acknowledge.
- `o_err` out 1: unmapped or misaligned access; asserted together with `o_ack`.
- `o_timer_interrupt` out N_HARTS: per-hart machine timer interrupt.
- `o_software_interrupt` out N_HARTS: per-hart MSIP.

## Operation
- Register map (offsets):
  - MSIP[h] at 0x0000+4h.
  - MTIMECMP[h] lo at 0x4000+8h, hi at 0x4004+8h.
  - MTIME lo at 0xBFF8, hi at 0xBFFC.
- Any other offset, h≥N_HARTS, or `i_addr[1:0]`≠0 is unmapped:
  - Reads return 0 with `o_err`=1.
  - Writes are dropped with `o_err`=1.
- Writes honour `i_wr_mask` per byte.
- MSIP:
  - Only bit 0 is stored, written when `i_wr_mask[0]`=1.
  - Reads return {31'b0, msip[h]}.
- Prescaler:
  - Counter `div_cnt` runs 0..TICK_DIV-1.
  - `tick`=1 when `div_cnt`==TICK_DIV-1, after which the counter returns to 0.
  - With TICK_DIV=1, `tick` is asserted every cycle.
- On `tick`, MTIME increments by 1 and wraps from 2^64-1 to 0.
- MTIME write priority:
  - A write to either MTIME half in a cycle suppresses that cycle's increment entirely.
  - The unwritten half holds its value.
  - `div_cnt` keeps running.
- Coherent MTIME read:
  - Reading MTIME lo captures `mtime[63:32]` into `shadow_hi` and sets `shadow_vld`.
  - Reading MTIME hi returns `shadow_hi` if `shadow_vld`=1, otherwise live `mtime[63:32]`. It always clears `shadow_vld`.
  - Any MTIME write clears `shadow_vld`.
- Timer interrupt: `o_timer_interrupt[h]` is registered as `mtime >= mtimecmp[h]`, an unsigned 64-bit compare. It stays asserted until `mtimecmp` is raised above `mtime`.
- `o_software_interrupt[h]` = `msip[h]`, driven directly from the flop.

## Timing
- Reset values:
  - `mtime`=0, `mtimecmp[*]`=all ones, `msip`=0.
  - `div_cnt`=0, `shadow_vld`=0, `shadow_hi`=0.
  - `o_ack`=0, `o_err`=0, `o_rdata`=0, `o_timer_interrupt`=0.
- Reset is asynchronous. Assertion mid-access drops the access; no ack is issued afterwards.
- Access latency is 1 cycle:
  - `o_ack` <= `i_stb` every cycle, so back-to-back strobes give back-to-back acks.
  - `o_rdata` holds the register value sampled at the stb edge.
  - `o_rdata` is cleared to 0 for writes and unmapped reads.
- Writes take effect at the stb edge. A read in the next cycle returns the new value.
- An MTIME lo read sees the value before that edge's increment.
- Interrupt timing:
  - `o_timer_interrupt` follows the compare with 1 cycle of delay.
  - A MTIMECMP write that clears the condition drops the interrupt 2 edges after the write strobe.

## Structure
- Package `asrv32_aclint_pkg`: offset constants `MSIP_OFS`, `MTIMECMP_OFS`, `MTIME_LO_OFS`, `MTIME_HI_OFS`, and a byte-mask merge function.
- Sub-module `asrv32_mtime_counter`: prescaler, 64-bit counter, write/increment priority. It exports `mtime` and `tick`.
- Top level: decode, per-hart register arrays (generate loop), shadow, ack/err/rdata flops, compare flops.

## Test plan
- Reset, then `mtimecmp[0]` lo=0x10 and hi=0, TICK_DIV=1 → `o_timer_interrupt[0]` rises exactly 1 cycle after `mtime` reaches 0x10. Then write hi=1 → interrupt falls.
- TICK_DIV=4: run 40 cycles from reset → `mtime`=10; `mtime` changes only every 4th cycle.
- Write MTIME lo=0xFFFF_FFFF and hi=0, read lo, wait for carry, read hi → hi read returns 0 (shadow), not 1. A second hi read returns 1.
- MSIP[1] write 0x1 with `i_wr_mask`=4'b0010 → no change. With 4'b0001 → `o_software_interrupt[1]`=1. Read returns 0x1.
- Access 0x0008 with N_HARTS=2, and 0xBFF9 (misaligned) → `o_ack`=1, `o_err`=1, `o_rdata`=0, no state change.
- Strobe asserted for 3 consecutive cycles (read, write, read of the same MTIMECMP) → 3 consecutive acks; the second read returns the written data. Assert `i_rst_n`=0 mid-burst → `o_ack`=0 immediately.
